mac_seq: RTL and testbench

//  Initiator that drives the mac block (a, b, clr_n in; acc, of, uf out) for one fully-connected layer.
//  Per output neuron: clears the MAC, streams N_IN input x weight pairs from two sync-read memories,

---
 rtl/mac_seq.sv | 152 +++++++++++++++
 tb/tb_mac_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq.sv
// Fully-connected layer sequencer: clears the MAC, streams N_IN products per neuron,
// saturates the accumulator to 8 bits and hands results out on valid/ready. Option: MAC_SEQ_RELU_EN.
module mac_seq #(
    parameter int N_IN       = 784,
    parameter int N_OUT      = 32,
    parameter int FRAC_SHIFT = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [((N_IN > 1) ? $clog2(N_IN) : 1)-1:0] in_addr,
    input  logic signed [7:0]      in_data,
    output logic [((N_IN*N_OUT > 1) ? $clog2(N_IN*N_OUT) : 1)-1:0] wt_addr,
    input  logic signed [7:0]      wt_data,
    output logic signed [7:0]      mac_a,
    output logic signed [7:0]      mac_b,
    output logic                   mac_clr_n,
    input  logic signed [15:0]     mac_acc,
    input  logic                   mac_of,
    input  logic                   mac_uf,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic signed [7:0]      res_data,
    output logic [((N_OUT > 1) ? $clog2(N_OUT) : 1)-1:0] res_idx
);
    // state   | meaning
    // IDLE    | waiting for start, MAC held cleared
    // CLR     | clear MAC and sticky flags, load address/timer
    // ACC     | issue N_IN addresses, products reach MAC one cycle later
    // SAT     | last product absorbed, register saturated result
    // OUT     | result offered downstream until accepted
    // DONE    | one-cycle done pulse
    localparam int WAW = (N_IN*N_OUT > 1) ? $clog2(N_IN*N_OUT) : 1;
    localparam int IAW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int NW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int CW  = $clog2(N_IN + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CLR  = 3'd1;
    localparam logic [2:0] S_ACC  = 3'd2;
    localparam logic [2:0] S_SAT  = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]         state;
    logic [CW-1:0]      cnt;
    logic [WAW-1:0]     wt_base;
    logic               prod_v;
    logic               st_of, st_uf;
    logic               eff_of, eff_uf;
    logic signed [15:0] shifted;
    logic signed [7:0]  sat_val;

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign res_valid = (state == S_OUT);
    assign mac_clr_n = !((state == S_IDLE) || (state == S_CLR));
    assign mac_a     = prod_v ? in_data : 8'sd0;
    assign mac_b     = prod_v ? wt_data : 8'sd0;

    // a flag seen this cycle replaces whatever was captured earlier
    always_comb begin
        eff_of = st_of;
        eff_uf = st_uf;
        if (mac_of) begin
            eff_of = 1'b1;
            eff_uf = 1'b0;
        end else if (mac_uf) begin
            eff_of = 1'b0;
            eff_uf = 1'b1;
        end
        shifted = mac_acc >>> FRAC_SHIFT;
        if (eff_of)
            sat_val = 8'sh7F;
        else if (eff_uf)
            sat_val = 8'sh80;
        else if (shifted > 16'sd127)
            sat_val = 8'sh7F;
        else if (shifted < -16'sd128)
            sat_val = 8'sh80;
        else
            sat_val = shifted[7:0];
`ifdef MAC_SEQ_RELU_EN
        if (sat_val[7])
            sat_val = 8'sd0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            wt_base  <= '0;
            prod_v   <= 1'b0;
            st_of    <= 1'b0;
            st_uf    <= 1'b0;
            in_addr  <= '0;
            wt_addr  <= '0;
            res_data <= '0;
            res_idx  <= '0;
        end else begin
            prod_v <= 1'b0;
            case (state)
                S_IDLE: if (start) state <= S_CLR;
                S_CLR: begin
                    cnt     <= CW'(N_IN);
                    in_addr <= '0;
                    wt_addr <= wt_base;
                    st_of   <= 1'b0;
                    st_uf   <= 1'b0;
                    state   <= S_ACC;
                end
                S_ACC: begin
                    prod_v <= (cnt != '0);
                    st_of  <= eff_of;
                    st_uf  <= eff_uf;
                    if (cnt > CW'(1)) begin
                        in_addr <= in_addr + IAW'(1);
                        wt_addr <= wt_addr + WAW'(1);
                    end
                    if (cnt == '0)
                        state <= S_SAT;
                    else
                        cnt <= cnt - CW'(1);
                end
                S_SAT: begin
                    st_of    <= eff_of;
                    st_uf    <= eff_uf;
                    res_data <= sat_val;
                    state    <= S_OUT;
                end
                S_OUT: begin
                    if (res_ready) begin
                        if (res_idx == NW'(N_OUT - 1)) begin
                            res_idx <= '0;
                            wt_base <= '0;
                            state   <= S_DONE;
                        end else begin
                            res_idx <= res_idx + NW'(1);
                            wt_base <= wt_base + WAW'(N_IN);
                            state   <= S_CLR;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq with a behavioural MAC and 1-cycle sync memories; results are
// checked against a per-neuron arithmetic reference (honours MAC_SEQ_RELU_EN).
module tb_mac_seq;
    localparam int N_IN = 4;
    localparam int N_OUT = 2;
    localparam int FRAC_SHIFT = 0;

    logic clk = 1'b0;
    logic rst, start, res_ready;
    logic busy, done, mac_clr_n, res_valid;
    logic mac_of, mac_uf;
    logic [1:0] in_addr;
    logic [2:0] wt_addr;
    logic [0:0] res_idx;
    logic signed [7:0] in_data, wt_data, mac_a, mac_b, res_data;
    logic signed [15:0] mac_acc;

    logic signed [7:0] in_mem [N_IN];
    logic signed [7:0] wt_mem [N_IN*N_OUT];

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    mac_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .FRAC_SHIFT(FRAC_SHIFT)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_addr(in_addr), .in_data(in_data), .wt_addr(wt_addr), .wt_data(wt_data),
        .mac_a(mac_a), .mac_b(mac_b), .mac_clr_n(mac_clr_n),
        .mac_acc(mac_acc), .mac_of(mac_of), .mac_uf(mac_uf),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx)
    );

    always #5 clk = ~clk;

    function automatic int mac_sum(input logic signed [15:0] acc, input logic signed [7:0] a,
                                   input logic signed [7:0] b);
        return int'(acc) + int'(a) * int'(b);
    endfunction

    // external MAC: wraps at 16 bits, of/uf reflect the most recent addition only
    always @(posedge clk) begin
        if (!mac_clr_n) begin
            mac_acc <= '0;
            mac_of  <= 1'b0;
            mac_uf  <= 1'b0;
        end else begin
            mac_acc <= 16'(mac_sum(mac_acc, mac_a, mac_b));
            mac_of  <= mac_sum(mac_acc, mac_a, mac_b) > 32767;
            mac_uf  <= mac_sum(mac_acc, mac_a, mac_b) < -32768;
        end
    end

    always @(posedge clk) begin
        in_data <= in_mem[in_addr];
        wt_data <= wt_mem[wt_addr];
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_res(input int n);
        int acc = 0;
        int s, r;
        int flag = 0;
        for (int i = 0; i < N_IN; i++) begin
            s = acc + int'(in_mem[i]) * int'(wt_mem[n*N_IN + i]);
            if (s > 32767) flag = 1;
            else if (s < -32768) flag = 2;
            acc = s;
            if (acc > 32767) acc -= 65536;
            else if (acc < -32768) acc += 65536;
        end
        if (flag == 1) r = 127;
        else if (flag == 2) r = -128;
        else begin
            r = acc >>> FRAC_SHIFT;
            if (r > 127) r = 127;
            if (r < -128) r = -128;
        end
`ifdef MAC_SEQ_RELU_EN
        if (r < 0) r = 0;
`endif
        return r;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_valid"}, int'(res_valid), 0);
        chk({tag, "_data"}, int'(res_data), 0);
        chk({tag, "_idx"}, int'(res_idx), 0);
        chk({tag, "_in_addr"}, int'(in_addr), 0);
        chk({tag, "_wt_addr"}, int'(wt_addr), 0);
        chk({tag, "_clr_n"}, int'(mac_clr_n), 0);
        chk({tag, "_mac_ab"}, int'(mac_a) + int'(mac_b), 0);
    endtask

    task automatic run_pass(input int stall, input bit extra_start);
        int waitc, d0, exp_d;
        logic signed [7:0] hold_d;
        logic [1:0] hold_a;
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < N_OUT; n++) begin
            chk("clr_n_low_in_clr", int'(mac_clr_n), 0);
            chk("busy", int'(busy), 1);
            waitc = 0;
            while (!res_valid && waitc < 40) begin
                if (extra_start && n == 0 && waitc == 2) start = 1'b1;
                tick();
                start = 1'b0;
                waitc++;
            end
            if (!res_valid) begin
                chk("valid_timeout", 0, 1);
                return;
            end
            chk("latency", waitc, N_IN + 3);
            exp_d = ref_res(n);
            chk("res_data", int'(res_data), exp_d);
            chk("res_idx", int'(res_idx), n);
            hold_d = res_data;
            hold_a = in_addr;
            for (int k = 0; k < ((n == 0) ? stall : 0); k++) begin
                tick();
                chk("stall_valid", int'(res_valid), 1);
                chk("stall_data", int'(res_data), int'(hold_d));
                chk("stall_idx", int'(res_idx), n);
                chk("stall_clr_n", int'(mac_clr_n), 1);
                chk("stall_addr", int'(in_addr), int'(hold_a));
            end
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            chk("valid_drop", int'(res_valid), 0);
        end
        chk("done_pulse", int'(done), 1);
        tick();
        chk("done_low", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
        tick();
        chk("one_done", done_cnt - d0, 1);
        chk("stay_idle", int'(busy), 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        res_ready = 1'b0;
        for (int i = 0; i < N_IN; i++) in_mem[i] = 8'sd1;
        wt_mem[0] = 8'sd2;  wt_mem[1] = 8'sd5;  wt_mem[2] = -8'sd2; wt_mem[3] = 8'sd5;
        wt_mem[4] = 8'sd2;  wt_mem[5] = 8'sd5;  wt_mem[6] = -8'sd2; wt_mem[7] = -8'sd8;
        repeat (3) tick();
        chk_reset_vals("rst");
        rst = 1'b0;
        tick();

        // known-value pass: 10 then -3, with backpressure on neuron 0
        run_pass(5, 1'b0);
        chk("s1_expect", ref_res(0), 10);

        // saturation: overflow then underflow, acc restarts from 0 per neuron
        for (int i = 0; i < N_IN; i++) begin
            in_mem[i] = 8'sd126;
            wt_mem[i] = 8'sd126;
            wt_mem[N_IN + i] = -8'sd100;
        end
        run_pass(0, 1'b0);

        // abort mid-accumulation, then a clean pass with a stray start while busy
        for (int i = 0; i < N_IN; i++) in_mem[i] = 8'sd1;
        wt_mem[0] = 8'sd2;  wt_mem[1] = 8'sd5;  wt_mem[2] = -8'sd2; wt_mem[3] = 8'sd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        chk_reset_vals("abort");
        begin
            int d0;
            d0 = done_cnt;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (res_valid || done) chk("abort_quiet", 1, 0);
            end
            chk("abort_no_done", done_cnt - d0, 0);
        end
        run_pass(0, 1'b1);

        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < N_IN; i++)
                in_mem[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10) - 5);
            for (int i = 0; i < N_IN*N_OUT; i++)
                wt_mem[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10) - 5);
            run_pass(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
